lsu_mem_if: RTL

//  Load/store unit between execute stage and data memory. Converts RV32I LB/LH/LW/LBU/LHU/
//  SB/SH/SW byte-addressed requests into word-indexed accesses on a word-only memory port.

---
 rtl/lsu_mem_if.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_if.sv
// Load/store unit: RV32I byte/half/word accesses onto a word-only memory port, SB/SH via read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned or out-of-range accesses with rsp_err instead of wrapping.
module lsu_mem_if #(
    parameter int MEM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;
    logic        rsp_err_reg;
    logic [31:0] wbuf_reg;
    logic [31:0] idx_reg;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        is_unsigned;
    logic        accept;
    logic        req_fault;
    logic        sw_fire;
    logic [31:0] req_idx;
    logic [31:0] merged;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // funct3[1] set means word width, which also absorbs the unsupported 011/110/111 encodings
    assign is_byte     = (req_funct3[1:0] == 2'b00);
    assign is_half     = (req_funct3[1:0] == 2'b01);
    assign is_word     = req_funct3[1];
    assign is_unsigned = req_funct3[2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_idx   = {2'b00, req_addr[31:2]};
    assign req_fault = (is_half && req_addr[0])
                    || (is_word && (req_addr[1:0] != 2'b00))
                    || (req_idx >= 32'(MEM_WORDS));
`else
    logic unused_addr;
    assign req_idx     = {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
    assign req_fault   = 1'b0;
    assign unused_addr = &{1'b0, req_addr[31:IDX_W+2]};
`endif

    assign req_ready = (state_reg == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign sw_fire   = accept && req_we && is_word && !req_fault;

    assign mem_wr_en = rst_n && ((state_reg == RMW_WR) || sw_fire);
    assign mem_addr  = (state_reg == RMW_WR) ? idx_reg  : req_idx;
    assign mem_wdata = (state_reg == RMW_WR) ? wbuf_reg : req_wdata;

    // Byte lanes for SB/SH merge: SB replicates wdata[7:0], SH places wdata[15:0] in the selected half
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = is_byte ? (req_addr[1:0] == 2'(gi))
                                      : (req_addr[1] == (gi >= 2));
            assign merged[gi*8 +: 8] = lane_hit
                ? (is_byte ? req_wdata[7:0] : req_wdata[(gi%2)*8 +: 8])
                : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (req_addr[1:0])
            2'b00: byte_sel = mem_rdata[7:0];
            2'b01: byte_sel = mem_rdata[15:8];
            2'b10: byte_sel = mem_rdata[23:16];
            2'b11: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (is_byte)
            load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        else if (is_half)
            load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        else
            load_data = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'h0;
            rsp_err_reg   <= 1'b0;
            wbuf_reg      <= 32'h0;
            idx_reg       <= 32'h0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (req_fault) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_data_reg  <= 32'h0;
                        end else if (!req_we) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b0;
                            rsp_data_reg  <= load_data;
                        end else if (is_word) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b0;
                            rsp_data_reg  <= 32'h0;
                        end else begin
                            wbuf_reg  <= merged;
                            idx_reg   <= req_idx;
                            state_reg <= RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b0;
                    rsp_data_reg  <= 32'h0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
